// File: rtl/poly_note_generator_pkg.sv
// Shared sample type, saturation helper and per-channel status struct for the
// poly_note_generator slice.
package note_gen_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   localparam sample_t SAMPLE_MAX = 16'sh7FFF;
   localparam sample_t SAMPLE_MIN = 16'sh8000;

   typedef struct packed {
      logic    active;
      sample_t sample;
   } ch_state_t;

   function automatic sample_t sat16(input logic signed [31:0] sum);
      if (sum > 32'(SAMPLE_MAX)) begin
         return SAMPLE_MAX;
      end else if (sum < 32'(SAMPLE_MIN)) begin
         return SAMPLE_MIN;
      end else begin
         return sample_t'(sum);
      end
   endfunction

endpackage

// File: rtl/poly_note_generator_channel.sv
// One square-wave note channel: divisor, half-period counter, phase and signed
// sample. With POLY_NOTE_GEN_ENVELOPE_EN an envelope level replaces the master volume.
module note_channel
   import note_gen_pkg::*;
#(
   parameter int unsigned    DIV_W    = 20,
   parameter int unsigned    VOL_W    = 3,
   parameter logic [15:0]    AMP_STEP = 16'h0800
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div_i,
   input  logic             load_i,
   input  logic [VOL_W-1:0] level_i,
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
   input  logic             tick_i,
`endif
   output ch_state_t        state_o
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [VOL_W-1:0] level;
   logic [SAMPLE_W-1:0] amp;
   logic             active;

`ifdef POLY_NOTE_GEN_ENVELOPE_EN
   logic [VOL_W-1:0] env_q, env_d;
   logic [VOL_W-1:0] target;
   logic             rel_q, rel_d;
`endif

   always_comb begin
      div_d   = div_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (div_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == div_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
      // A zero-divisor load only marks release; the old note keeps sounding until env decays.
      env_d  = env_q;
      rel_d  = rel_q;
      target = ((div_q != '0) && !rel_q) ? level_i : '0;
      if (tick_i) begin
         if (env_q < target) begin
            env_d = env_q + 1'b1;
         end else if (env_q > target) begin
            env_d = env_q - 1'b1;
         end
      end
      if (rel_q && (env_q == '0)) begin
         div_d   = '0;
         cnt_d   = '0;
         phase_d = 1'b0;
         rel_d   = 1'b0;
      end
      if (load_i) begin
         if (div_i == '0) begin
            rel_d = 1'b1;
         end else begin
            div_d   = div_i;
            cnt_d   = '0;
            phase_d = 1'b0;
            rel_d   = 1'b0;
         end
      end
      level = env_q;
`else
      if (load_i) begin
         div_d   = div_i;
         cnt_d   = '0;
         phase_d = 1'b0;
      end
      level = level_i;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
         env_q   <= '0;
         rel_q   <= 1'b0;
`endif
      end else begin
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
         env_q   <= env_d;
         rel_q   <= rel_d;
`endif
      end
   end

   always_comb begin
      amp    = SAMPLE_W'(level) * AMP_STEP;
      active = (level != '0) && (div_q != '0);
      state_o.active = active;
      if (!active) begin
         state_o.sample = '0;
      end else if (phase_q) begin
         state_o.sample = sample_t'(amp);
      end else begin
         state_o.sample = sample_t'(-amp);
      end
   end

endmodule

// File: rtl/poly_note_generator.sv
// CH-channel square-wave note generator with master volume, stereo routing and
// saturated mixer. Optional macro: POLY_NOTE_GEN_ENVELOPE_EN (per-channel envelopes).
module poly_note_generator
   import note_gen_pkg::*;
#(
   parameter int unsigned CH        = 4,
   parameter int unsigned DIV_W     = 20,
   parameter int unsigned VOL_W     = 3,
   parameter int unsigned VOL_RESET = 3,
   parameter logic [15:0] AMP_STEP  = 16'h0800,
   parameter int unsigned ENV_TICK  = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH*DIV_W-1:0] note_div,
   input  logic [CH-1:0]       note_load,
   input  logic [CH-1:0]       pan_l,
   input  logic [CH-1:0]       pan_r,
   input  logic                vol_up,
   input  logic                vol_down,
   output logic [VOL_W-1:0]    volume,
   output logic [CH-1:0]       ch_active,
   output logic signed [15:0]  audio_left,
   output logic signed [15:0]  audio_right
);

   localparam int unsigned      MIX_W   = SAMPLE_W + $clog2(CH);
   localparam logic [VOL_W-1:0] VOL_MAX = '1;

   logic [VOL_W-1:0] vol_q, vol_d;
   ch_state_t        ch_st [CH];
   logic signed [MIX_W-1:0] sum_l, sum_r;
   sample_t          left_q, left_d, right_q, right_d;
   logic [CH-1:0]    act_q, act_d;

   always_comb begin
      vol_d = vol_q;
      if (vol_up && !vol_down && (vol_q != VOL_MAX)) begin
         vol_d = vol_q + 1'b1;
      end else if (vol_down && !vol_up && (vol_q != '0)) begin
         vol_d = vol_q - 1'b1;
      end
   end

`ifdef POLY_NOTE_GEN_ENVELOPE_EN
   localparam int unsigned TICK_W = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;
   logic [TICK_W-1:0] tick_q;
   logic              env_tick;

   assign env_tick = (tick_q == TICK_W'(ENV_TICK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
      end else begin
         tick_q <= env_tick ? '0 : tick_q + 1'b1;
      end
   end
`endif

   for (genvar g = 0; g < CH; g++) begin : g_ch
      note_channel #(
         .DIV_W    (DIV_W),
         .VOL_W    (VOL_W),
         .AMP_STEP (AMP_STEP)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .div_i   (note_div[g*DIV_W +: DIV_W]),
         .load_i  (note_load[g]),
         .level_i (vol_q),
`ifdef POLY_NOTE_GEN_ENVELOPE_EN
         .tick_i  (env_tick),
`endif
         .state_o (ch_st[g])
      );
   end

   always_comb begin
      sum_l = '0;
      sum_r = '0;
      act_d = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (pan_l[i]) sum_l = sum_l + MIX_W'($signed(ch_st[i].sample));
         if (pan_r[i]) sum_r = sum_r + MIX_W'($signed(ch_st[i].sample));
         act_d[i] = ch_st[i].active;
      end
      left_d  = sat16(32'(sum_l));
      right_d = sat16(32'(sum_r));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vol_q   <= VOL_W'(VOL_RESET);
         left_q  <= '0;
         right_q <= '0;
         act_q   <= '0;
      end else begin
         vol_q   <= vol_d;
         left_q  <= left_d;
         right_q <= right_d;
         act_q   <= act_d;
      end
   end

   assign volume      = vol_q;
   assign ch_active   = act_q;
   assign audio_left  = left_q;
   assign audio_right = right_q;

endmodule

// File: tb/tb_poly_note_generator.sv
// Self-checking bench for poly_note_generator (default build, envelope macro undefined).
module tb_poly_note_generator;

   localparam int CH    = 4;
   localparam int DIV_W = 20;

   logic                clk;
   logic                rst_n;
   logic [CH*DIV_W-1:0] note_div;
   logic [CH-1:0]       note_load, pan_l, pan_r;
   logic                vol_up, vol_down;
   logic [2:0]          volume;
   logic [CH-1:0]       ch_active;
   logic signed [15:0]  audio_left, audio_right;

   poly_note_generator #(
      .CH(4), .DIV_W(20), .VOL_W(3), .VOL_RESET(3), .AMP_STEP(16'h0800), .ENV_TICK(1024)
   ) dut (
      .clk(clk), .rst_n(rst_n), .note_div(note_div), .note_load(note_load),
      .pan_l(pan_l), .pan_r(pan_r), .vol_up(vol_up), .vol_down(vol_down),
      .volume(volume), .ch_active(ch_active),
      .audio_left(audio_left), .audio_right(audio_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: each channel is described by its divisor and the number of
   // cycles elapsed since it was (re)loaded; phase follows from plain division.
   int m_div [CH];
   int m_t   [CH];
   int m_vol;
   int exp_l, exp_r;
   logic [CH-1:0] exp_act;

   function automatic int m_phase(int i);
      if (m_div[i] == 0) return 0;
      return (m_t[i] / (m_div[i] + 1)) % 2;
   endfunction

   function automatic int m_sample(int i);
      int amp;
      if (m_div[i] == 0 || m_vol == 0) return 0;
      amp = m_vol * 2048;
      return (m_phase(i) == 1) ? amp : -amp;
   endfunction

   function automatic int sat(int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_div[i] = 0;
         m_t[i]   = 0;
      end
      m_vol   = 3;
      exp_l   = 0;
      exp_r   = 0;
      exp_act = '0;
   endtask

   // Advances DUT and model by one clock; leaves expected outputs in exp_*.
   task automatic cycle();
      int sl, sr;
      sl = 0;
      sr = 0;
      for (int i = 0; i < CH; i++) begin
         if (pan_l[i]) sl += m_sample(i);
         if (pan_r[i]) sr += m_sample(i);
         exp_act[i] = (m_div[i] != 0) && (m_vol != 0);
      end
      exp_l = sat(sl);
      exp_r = sat(sr);
      for (int i = 0; i < CH; i++) begin
         if (note_load[i]) begin
            m_div[i] = int'(note_div[i*DIV_W +: DIV_W]);
            m_t[i]   = 0;
         end else if (m_div[i] != 0) begin
            m_t[i]++;
         end
      end
      if (vol_up && !vol_down && m_vol < 7) m_vol++;
      else if (vol_down && !vol_up && m_vol > 0) m_vol--;
      @(posedge clk);
      #1;
      note_load = '0;
      vol_up    = 1'b0;
      vol_down  = 1'b0;
   endtask

   task automatic set_div(int ch, int val);
      note_div[ch*DIV_W +: DIV_W] = DIV_W'(val);
      note_load[ch] = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total += 4;
      if (audio_left !== 16'sd0) begin bad++; $display("FAIL reset_left got=%0d exp=0", audio_left); end
      if (audio_right !== 16'sd0) begin bad++; $display("FAIL reset_right got=%0d exp=0", audio_right); end
      if (volume !== 3'd3) begin bad++; $display("FAIL reset_volume got=%0d exp=3", volume); end
      if (ch_active !== 4'b0000) begin bad++; $display("FAIL reset_active got=%b exp=0000", ch_active); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_tone();
      int cur, prev, run;
      pan_l = 4'b0001;
      pan_r = 4'b0001;
      set_div(0, 4);
      cycle();
      run = 0;
      prev = 0;
      for (int k = 0; k < 22; k++) begin
         cycle();
         cur = int'(audio_left);
         total += 4;
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL tone_left got=%0d exp=%0d", audio_left, exp_l); end
         if (int'(audio_right) !== exp_r) begin bad++; $display("FAIL tone_right got=%0d exp=%0d", audio_right, exp_r); end
         if (ch_active !== exp_act) begin bad++; $display("FAIL tone_active got=%b exp=%b", ch_active, exp_act); end
         if (cur != 6144 && cur != -6144) begin bad++; $display("FAIL tone_amp got=%0d exp=+-6144", cur); end
         if (k > 0 && cur != prev) begin
            total++;
            if (run != 5) begin bad++; $display("FAIL tone_halfperiod got=%0d exp=5", run); end
            run = 1;
         end else begin
            run++;
         end
         prev = cur;
      end
   endtask

   task automatic test_volume();
      int ev;
      ev = 3;
      for (int k = 0; k < 6; k++) begin
         vol_up = 1'b1;
         cycle();
         ev = (ev < 7) ? ev + 1 : 7;
         total += 2;
         if (int'(volume) !== ev) begin bad++; $display("FAIL vol_up got=%0d exp=%0d", volume, ev); end
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL vol_left got=%0d exp=%0d", audio_left, exp_l); end
      end
      vol_up = 1'b1;
      vol_down = 1'b1;
      cycle();
      total++;
      if (volume !== 3'd7) begin bad++; $display("FAIL vol_both got=%0d exp=7", volume); end
      for (int k = 0; k < 9; k++) begin
         vol_down = 1'b1;
         cycle();
         ev = (ev > 0) ? ev - 1 : 0;
         total += 3;
         if (int'(volume) !== ev) begin bad++; $display("FAIL vol_down got=%0d exp=%0d", volume, ev); end
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL vol_dn_left got=%0d exp=%0d", audio_left, exp_l); end
         if (ch_active !== exp_act) begin bad++; $display("FAIL vol_dn_active got=%b exp=%b", ch_active, exp_act); end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 7; k++) begin
         vol_up = 1'b1;
         cycle();
      end
      pan_l = 4'b1111;
      pan_r = 4'b1111;
      for (int i = 0; i < CH; i++) set_div(i, 3);
      cycle();
      cycle();
      total += 2;
      if (audio_left !== 16'sh8000) begin bad++; $display("FAIL sat_neg_left got=%0d exp=-32768", audio_left); end
      if (audio_right !== 16'sh8000) begin bad++; $display("FAIL sat_neg_right got=%0d exp=-32768", audio_right); end
      for (int k = 0; k < 4; k++) cycle();
      total += 3;
      if (audio_left !== 16'sh7FFF) begin bad++; $display("FAIL sat_pos_left got=%0d exp=32767", audio_left); end
      if (audio_right !== 16'sh7FFF) begin bad++; $display("FAIL sat_pos_right got=%0d exp=32767", audio_right); end
      if (ch_active !== 4'b1111) begin bad++; $display("FAIL sat_active got=%b exp=1111", ch_active); end
   endtask

   task automatic test_pan();
      pan_l = 4'b0001;
      pan_r = 4'b0010;
      set_div(0, 4);
      set_div(1, 6);
      cycle();
      for (int k = 0; k < 30; k++) begin
         cycle();
         total += 4;
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL pan_left got=%0d exp=%0d", audio_left, exp_l); end
         if (int'(audio_right) !== exp_r) begin bad++; $display("FAIL pan_right got=%0d exp=%0d", audio_right, exp_r); end
         if (audio_left != 16'sh3800 && audio_left != -16'sh3800) begin bad++; $display("FAIL pan_l_amp got=%0d exp=+-14336", audio_left); end
         if (audio_right != 16'sh3800 && audio_right != -16'sh3800) begin bad++; $display("FAIL pan_r_amp got=%0d exp=+-14336", audio_right); end
      end
   endtask

   task automatic test_reload();
      int cur, prev, run;
      pan_l = 4'b0001;
      pan_r = 4'b0001;
      set_div(0, 9);
      cycle();
      for (int k = 0; k < 7; k++) cycle();
      set_div(0, 2);
      cycle();
      run = 0;
      prev = 0;
      for (int k = 0; k < 15; k++) begin
         cycle();
         cur = int'(audio_left);
         total += 2;
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL reload_left got=%0d exp=%0d", audio_left, exp_l); end
         if (k == 0 && cur >= 0) begin bad++; $display("FAIL reload_phase0 got=%0d exp=negative", cur); end
         if (k > 0 && cur != prev) begin
            total++;
            if (run != 3) begin bad++; $display("FAIL reload_halfperiod got=%0d exp=3", run); end
            run = 1;
         end else begin
            run++;
         end
         prev = cur;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < CH; i++)
            if ($urandom_range(39, 0) == 0) set_div(i, int'($urandom_range(12, 0)));
         if ($urandom_range(49, 0) == 0) begin
            pan_l = 4'($urandom);
            pan_r = 4'($urandom);
         end
         vol_up   = ($urandom_range(29, 0) == 0);
         vol_down = ($urandom_range(29, 0) == 0);
         cycle();
         total += 4;
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL rnd_left got=%0d exp=%0d", audio_left, exp_l); end
         if (int'(audio_right) !== exp_r) begin bad++; $display("FAIL rnd_right got=%0d exp=%0d", audio_right, exp_r); end
         if (int'(volume) !== m_vol) begin bad++; $display("FAIL rnd_volume got=%0d exp=%0d", volume, m_vol); end
         if (ch_active !== exp_act) begin bad++; $display("FAIL rnd_active got=%b exp=%b", ch_active, exp_act); end
      end
   endtask

   task automatic test_reset_mid();
      pan_l = 4'b0011;
      pan_r = 4'b0011;
      vol_up = 1'b1;
      set_div(0, 3);
      set_div(1, 5);
      cycle();
      for (int k = 0; k < 8; k++) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      total += 4;
      if (audio_left !== 16'sd0) begin bad++; $display("FAIL midrst_left got=%0d exp=0", audio_left); end
      if (audio_right !== 16'sd0) begin bad++; $display("FAIL midrst_right got=%0d exp=0", audio_right); end
      if (volume !== 3'd3) begin bad++; $display("FAIL midrst_volume got=%0d exp=3", volume); end
      if (ch_active !== 4'b0000) begin bad++; $display("FAIL midrst_active got=%b exp=0000", ch_active); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         total++;
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL postrst_left got=%0d exp=%0d", audio_left, exp_l); end
      end
      set_div(1, 2);
      cycle();
      for (int k = 0; k < 10; k++) begin
         cycle();
         total += 3;
         if (int'(audio_left) !== exp_l) begin bad++; $display("FAIL recover_left got=%0d exp=%0d", audio_left, exp_l); end
         if (int'(audio_right) !== exp_r) begin bad++; $display("FAIL recover_right got=%0d exp=%0d", audio_right, exp_r); end
         if (ch_active !== exp_act) begin bad++; $display("FAIL recover_active got=%b exp=%b", ch_active, exp_act); end
      end
   endtask

   initial begin
      note_div  = '0;
      note_load = '0;
      pan_l     = '0;
      pan_r     = '0;
      vol_up    = 1'b0;
      vol_down  = 1'b0;
      test_reset();
      test_single_tone();
      test_volume();
      test_saturation();
      test_pan();
      test_reload();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
